seg_display_scheduler: RTL



---
 rtl/seg_pkg.sv | 33 +++
 rtl/seg_display_scheduler_hex_to_seg7.sv | 14 +
 rtl/seg_display_scheduler.sv | 117 +++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared constants and state encoding for the seven-segment scan controller.
package seg_pkg;

    // Active-low segment patterns {g,f,e,d,c,b,a}, indexed by hex nibble value.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E,  // F
        7'h06,  // E
        7'h21,  // d
        7'h46,  // C
        7'h03,  // b
        7'h08,  // A
        7'h10,  // 9
        7'h00,  // 8
        7'h78,  // 7
        7'h02,  // 6
        7'h12,  // 5
        7'h19,  // 4
        7'h30,  // 3
        7'h24,  // 2
        7'h79,  // 1
        7'h40   // 0
    };

    localparam logic [3:0] ANODES_OFF = 4'b1111;
    localparam logic [6:0] SEGS_OFF   = 7'b1111111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/seg_display_scheduler_hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_seg7
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Table lookup straight from the package constants.
    always_comb begin
        seg = HEX_SEG[nibble];
    end

endmodule

// File: rtl/seg_display_scheduler.sv
// Four-digit common-anode display scheduler: captures the adder result,
// shows one 16-bit page as hex and scans anodes with dwell and blank gap.
module seg_display_scheduler
    import seg_pkg::*;
#(
    parameter int DWELL = 32,
    parameter int GAP   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        result_valid,
    input  logic [31:0] result_in,
    input  logic        page_toggle,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        page
);

    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);
    localparam logic [7:0] GAP_LAST   = 8'((GAP > 0) ? (GAP - 1) : 0);
    localparam bit         HAS_GAP    = (GAP > 0);

    state_t      state;
    logic [31:0] data;
    logic [1:0]  digit;
    logic [7:0]  cnt;

    logic [31:0] data_next;
    logic        page_next;
    logic [1:0]  next_digit;
    logic [15:0] half;
    logic [3:0]  nibble;
    logic [6:0]  seg_next;
    logic [3:0]  an_next;
    logic        dp_next;

    // Values a DRIVE entry on this edge would load; they see same-edge
    // captures and page flips so the freshly lit digit is never stale.
    always_comb begin
        data_next  = result_valid ? result_in : data;
        page_next  = page ^ page_toggle;
        next_digit = (state == ST_IDLE) ? 2'd0 : digit + 2'd1;
        half       = page_next ? data_next[31:16] : data_next[15:0];
        nibble     = half[{next_digit, 2'b00} +: 4];
        an_next    = ~(4'b0001 << next_digit);
        dp_next    = ~((next_digit == 2'd3) && page_next);
    end

    hex_to_seg7 u_dec (
        .nibble (nibble),
        .seg    (seg_next)
    );

    // Scan FSM, dwell/gap counter, data register, page flop and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            data  <= 32'd0;
            digit <= 2'd0;
            cnt   <= 8'd0;
            page  <= 1'b0;
            an    <= ANODES_OFF;
            seg   <= SEGS_OFF;
            dp    <= 1'b1;
        end else begin
            data <= data_next;
            page <= page_next;
            case (state)
                ST_IDLE: begin
                    if (result_valid) begin
                        state <= ST_DRIVE;
                        digit <= 2'd0;
                        cnt   <= 8'd0;
                        an    <= an_next;
                        seg   <= seg_next;
                        dp    <= dp_next;
                    end
                end
                ST_DRIVE: begin
                    if (cnt == DWELL_LAST) begin
                        cnt <= 8'd0;
                        if (HAS_GAP) begin
                            state <= ST_GAP;
                            an    <= ANODES_OFF;
                            seg   <= SEGS_OFF;
                            dp    <= 1'b1;
                        end else begin
                            digit <= next_digit;
                            an    <= an_next;
                            seg   <= seg_next;
                            dp    <= dp_next;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_GAP: begin
                    if (cnt == GAP_LAST) begin
                        state <= ST_DRIVE;
                        cnt   <= 8'd0;
                        digit <= next_digit;
                        an    <= an_next;
                        seg   <= seg_next;
                        dp    <= dp_next;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
